// File: rtl/alu_pkg.sv
// Shared ALU constants: widths, opcodes, unary mask, sequencer states.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W = 3;
  localparam logic [7:0] UNARY_MASK = 8'b0010_0000;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [2:0] {
    S_GET_OP = 3'd0,
    S_GET_A  = 3'd1,
    S_GET_B  = 3'd2,
    S_ISSUE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Issue bundle from the operand sequencer to the ALU.
interface alu_operand_sequencer_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OP_W-1:0]   opcode;
  logic              issue_valid;
  logic              issue_ready;

  modport master (
    output op_a,
    output op_b,
    output opcode,
    output issue_valid,
    input  issue_ready
  );

  modport slave (
    input  op_a,
    input  op_b,
    input  opcode,
    input  issue_valid,
    output issue_ready
  );

endinterface

// File: rtl/key_rise_detect.sv
// Rising-edge pulse from a synchronised key level.
module key_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic hist;

  // Reset to 1 so a key held through reset yields no edge.
  always_ff @(posedge clk) begin
    if (reset) hist <= 1'b1;
    else       hist <= key;
  end

  assign rise = key & ~hist;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects opcode/operands from switches and issues them to the ALU.
module alu_operand_sequencer #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter logic [(2**OP_W)-1:0] UNARY_MASK = alu_pkg::UNARY_MASK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_confirm,
  input  logic              key_cancel,
  input  logic [DATA_W-1:0] sw_data,
  alu_operand_sequencer_if.master bus,
  output logic              busy,
  output logic [2:0]        stage
);
  import alu_pkg::*;

  logic   conf_e;
  logic   canc_e;
  state_t state;

  key_rise_detect u_conf (
    .clk   (clk),
    .reset (reset),
    .key   (key_confirm),
    .rise  (conf_e)
  );

  key_rise_detect u_canc (
    .clk   (clk),
    .reset (reset),
    .key   (key_cancel),
    .rise  (canc_e)
  );

  assign stage = 3'(state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_GET_OP;
      bus.op_a        <= '0;
      bus.op_b        <= '0;
      bus.opcode      <= '0;
      bus.issue_valid <= 1'b0;
      busy            <= 1'b0;
    end else if (canc_e && state != S_ISSUE) begin
      // Cancel beats a simultaneous confirm.
      state      <= S_GET_OP;
      bus.op_a   <= '0;
      bus.op_b   <= '0;
      bus.opcode <= '0;
    end else begin
      unique case (state)
        S_GET_OP: begin
          if (conf_e) begin
            bus.opcode <= sw_data[OP_W-1:0];
            state      <= S_GET_A;
          end
        end
        S_GET_A: begin
          if (conf_e) begin
            bus.op_a <= sw_data;
            if (UNARY_MASK[bus.opcode]) begin
              bus.op_b        <= '0;
              state           <= S_ISSUE;
              bus.issue_valid <= 1'b1;
              busy            <= 1'b1;
            end else begin
              state <= S_GET_B;
            end
          end
        end
        S_GET_B: begin
          if (conf_e) begin
            bus.op_b        <= sw_data;
            state           <= S_ISSUE;
            bus.issue_valid <= 1'b1;
            busy            <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.issue_ready) begin
            state           <= S_DONE;
            bus.issue_valid <= 1'b0;
            busy            <= 1'b0;
          end
        end
        S_DONE: begin
          if (conf_e) state <= S_GET_OP;
        end
        default: begin
          state           <= S_GET_OP;
          bus.issue_valid <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench: directed scenarios plus random keys against a behavioural model.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_confirm;
  logic       key_cancel;
  logic [7:0] sw_data;
  logic       busy;
  logic [2:0] stage;

  alu_operand_sequencer_if bus();

  alu_operand_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .key_confirm (key_confirm),
    .key_cancel  (key_cancel),
    .sw_data     (sw_data),
    .bus         (bus),
    .busy        (busy),
    .stage       (stage)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: count of values collected, offer/done flags.
  logic [7:0] unary = 8'h20;
  logic [7:0] m_a, m_b;
  logic [2:0] m_opc;
  int         m_n;
  bit         m_offer, m_done, pc, px, ce, xe, started;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      m_a = 0; m_b = 0; m_opc = 0; m_n = 0;
      m_offer = 0; m_done = 0; pc = 1; px = 1;
    end else begin
      ce = key_confirm && !pc;
      xe = key_cancel && !px;
      pc = key_confirm;
      px = key_cancel;
      if (m_offer) begin
        if (bus.issue_ready) begin
          m_offer = 0; m_done = 1; m_n = 0;
        end
      end else if (xe) begin
        m_a = 0; m_b = 0; m_opc = 0; m_n = 0; m_done = 0;
      end else if (ce) begin
        if (m_done) m_done = 0;
        else if (m_n == 0) begin
          m_opc = sw_data[2:0]; m_n = 1;
        end else if (m_n == 1) begin
          m_a = sw_data;
          if (unary[m_opc]) begin m_b = 0; m_offer = 1; end
          else m_n = 2;
        end else begin
          m_b = sw_data; m_offer = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_op_a", bus.op_a, m_a);
      chk("m_op_b", bus.op_b, m_b);
      chk("m_opcode", bus.opcode, m_opc);
      chk("m_valid", bus.issue_valid, m_offer);
      chk("m_busy", busy, m_offer);
      chk("m_stage", stage, m_offer ? 3 : (m_done ? 4 : m_n));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [7:0] v);
    sw_data = v;
    key_confirm = 1'b1;
    step();
    key_confirm = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    key_confirm = 1'b1;
    key_cancel = 1'b0;
    sw_data = 8'h00;
    bus.issue_ready = 1'b1;

    // 1: held confirm through reset gives no edge
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_stage", stage, 0);
    end
    chk("rst_valid", bus.issue_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();
    chk("held_stage", stage, 0);
    key_confirm = 1'b0;
    step();
    chk("rel_stage", stage, 0);
    chk("rel_opcode", bus.opcode, 0);

    // 2: binary op
    press(8'h00);
    chk("bin_s1", stage, 1);
    press(8'h3C);
    chk("bin_s2", stage, 2);
    sw_data = 8'h0F;
    key_confirm = 1'b1;
    step();
    chk("bin_valid", bus.issue_valid, 1);
    chk("bin_a", bus.op_a, 8'h3C);
    chk("bin_b", bus.op_b, 8'h0F);
    chk("bin_opc", bus.opcode, 0);
    key_confirm = 1'b0;
    step();
    chk("bin_done", stage, 4);
    chk("bin_vlow", bus.issue_valid, 0);

    // 3: unary NOT skips operand B
    press(8'h00);
    chk("un_s0", stage, 0);
    press(8'h05);
    chk("un_opc", bus.opcode, 5);
    sw_data = 8'hA5;
    key_confirm = 1'b1;
    step();
    chk("un_stage", stage, 3);
    chk("un_valid", bus.issue_valid, 1);
    chk("un_a", bus.op_a, 8'hA5);
    chk("un_b", bus.op_b, 8'h00);
    key_confirm = 1'b0;
    step();
    chk("un_done", stage, 4);

    // 4: backpressure, keys ignored in ISSUE
    bus.issue_ready = 1'b0;
    press(8'h00);
    press(8'h01);
    press(8'h11);
    sw_data = 8'h22;
    key_confirm = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      key_confirm = (i % 2) != 0;
      key_cancel = (i % 2) == 0;
      step();
      chk("bp_valid", bus.issue_valid, 1);
      chk("bp_a", bus.op_a, 8'h11);
      chk("bp_b", bus.op_b, 8'h22);
    end
    key_confirm = 1'b0;
    key_cancel = 1'b0;
    bus.issue_ready = 1'b1;
    step();
    chk("bp_done", stage, 4);

    // 5: cancel
    press(8'h00);
    press(8'h01);
    press(8'h55);
    chk("cn_a55", bus.op_a, 8'h55);
    key_cancel = 1'b1;
    step();
    chk("cn_stage", stage, 0);
    chk("cn_a0", bus.op_a, 8'h00);
    key_cancel = 1'b0;
    step();
    press(8'h03);
    sw_data = 8'h77;
    key_confirm = 1'b1;
    key_cancel = 1'b1;
    step();
    chk("both_stage", stage, 0);
    chk("both_a", bus.op_a, 0);
    chk("both_opc", bus.opcode, 0);
    key_confirm = 1'b0;
    key_cancel = 1'b0;
    step();

    // 6: held level captures once; reset mid-ISSUE
    sw_data = 8'h02;
    key_confirm = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("hold_opc", bus.opcode, 2);
    chk("hold_stage", stage, 1);
    key_confirm = 1'b0;
    step();
    bus.issue_ready = 1'b0;
    press(8'h99);
    sw_data = 8'h44;
    key_confirm = 1'b1;
    step();
    chk("ri_valid", bus.issue_valid, 1);
    reset = 1'b1;
    key_confirm = 1'b0;
    step();
    chk("ri_vlow", bus.issue_valid, 0);
    chk("ri_stage", stage, 0);
    chk("ri_busy", busy, 0);
    chk("ri_a", bus.op_a, 0);
    reset = 1'b0;
    step();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      key_confirm = ($urandom_range(0, 2) == 0);
      key_cancel = ($urandom_range(0, 11) == 0);
      sw_data = 8'($urandom);
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
